// File: rtl/div_pkg.sv
// ----------------------------------------------------------------------------
// div_pkg: shared types and constants for the iterative divider.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);
  localparam logic [DIV_WIDTH-1:0] DIV_Z_QUOT = '1;

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ----------------------------------------------------------------------------
// div_step: one combinational restoring-division iteration on {rem, quot}.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quot_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quot_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // The partial remainder is always below the divisor, so the shifted value
  // fits in WIDTH+1 bits and diff's MSB is a true sign bit.
  assign shifted = {rem_i, quot_i[WIDTH-1]};
  assign diff    = shifted - {1'b0, div_i};

  assign rem_o  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quot_o = {quot_i[WIDTH-2:0], ~diff[WIDTH]};

endmodule

`default_nettype wire

// File: rtl/div_iter.sv
// ----------------------------------------------------------------------------
// div_iter: iterative MIPS DIV/DIVU unit with hazard stall request.
// Optional build macro DIV_EARLY_OUT_EN: skip iterations when |a| < |b|.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module div_iter
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             annul_i,
  output logic             stall_o,
  output logic             ready_o,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] res_quot_q, res_quot_d;
  logic [WIDTH-1:0] res_rem_q, res_rem_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;

  logic             go;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH-1:0] step_rem, step_quot;

  assign go    = start_i & ~annul_i;
  assign a_abs = (signed_i & a_i[WIDTH-1]) ? -a_i : a_i;
  assign b_abs = (signed_i & b_i[WIDTH-1]) ? -b_i : b_i;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i  (rem_q),
    .quot_i (quot_q),
    .div_i  (div_q),
    .rem_o  (step_rem),
    .quot_o (step_quot)
  );

  // Results land in the output registers on the edge into DONE, so they are
  // valid in the same cycle ready_o is raised.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    div_d      = div_q;
    negq_d     = negq_q;
    negr_d     = negr_q;
    res_quot_d = res_quot_q;
    res_rem_d  = res_rem_q;
    case (state_q)
      IDLE: begin
        if (go) begin
          negq_d = signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
          negr_d = signed_i & a_i[WIDTH-1];
          div_d  = b_abs;
          rem_d  = '0;
          quot_d = a_abs;
          if (b_i == '0) begin
            state_d    = DONE;
            res_quot_d = {WIDTH{DIV_Z_QUOT[0]}};
            res_rem_d  = a_i;
          end
`ifdef DIV_EARLY_OUT_EN
          else if (a_abs < b_abs) begin
            state_d    = DONE;
            res_quot_d = '0;
            res_rem_d  = a_i;
          end
`endif
          else begin
            state_d = BUSY;
            cnt_d   = CNT_W'(WIDTH - 1);
          end
        end
      end
      BUSY: begin
        // A dropped start without annul is treated exactly like an annul.
        if (!go) begin
          state_d = IDLE;
        end else begin
          rem_d  = step_rem;
          quot_d = step_quot;
          cnt_d  = cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            state_d    = DONE;
            res_quot_d = negq_q ? -step_quot : step_quot;
            res_rem_d  = negr_q ? -step_rem : step_rem;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      div_q      <= '0;
      negq_q     <= 1'b0;
      negr_q     <= 1'b0;
      res_quot_q <= '0;
      res_rem_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      div_q      <= div_d;
      negq_q     <= negq_d;
      negr_q     <= negr_d;
      res_quot_q <= res_quot_d;
      res_rem_q  <= res_rem_d;
    end
  end

  assign stall_o = go & (state_q != DONE);
  assign ready_o = (state_q == DONE) & ~annul_i;
  assign quot_o  = res_quot_q;
  assign rem_o   = res_rem_q;

endmodule

`default_nettype wire

// File: tb/tb_div_iter.sv
// ----------------------------------------------------------------------------
// tb_div_iter: self-checking bench for div_iter against an arithmetic model.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_div_iter;
  import div_pkg::*;

  localparam int W = DIV_WIDTH;

  logic         clk = 1'b0;
  logic         resetn;
  logic         start_i;
  logic         signed_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         annul_i;
  logic         stall_o;
  logic         ready_o;
  logic [W-1:0] quot_o;
  logic [W-1:0] rem_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  div_iter #(.WIDTH(W)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start_i  (start_i),
    .signed_i (signed_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .annul_i  (annul_i),
    .stall_o  (stall_o),
    .ready_o  (ready_o),
    .quot_o   (quot_o),
    .rem_o    (rem_o)
  );

  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic sgn,
                                output logic [W-1:0] q, output logic [W-1:0] r);
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = '0;
    end else begin
      q = W'($signed(a) / $signed(b));
      r = W'($signed(a) % $signed(b));
    end
  endfunction

  function automatic int model_lat(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sgn);
    logic [W-1:0] ma, mb;
    ma = (sgn && a[W-1]) ? -a : a;
    mb = (sgn && b[W-1]) ? -b : b;
    if (b == '0) return 1;
`ifdef DIV_EARLY_OUT_EN
    if (ma < mb) return 1;
`endif
    if (ma == mb) return W + 1;
    return W + 1;
  endfunction

  // Launches one divide and holds start until ready; start stays high after.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output int nstall, output int rdy_cyc, output logic stall_at_rdy);
    @(posedge clk); #1;
    start_i  = 1'b1;
    annul_i  = 1'b0;
    a_i      = a;
    b_i      = b;
    signed_i = sgn;
    nstall   = 0;
    rdy_cyc  = -1;
    q        = '0;
    r        = '0;
    stall_at_rdy = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (ready_o) begin
        rdy_cyc      = c;
        q            = quot_o;
        r            = rem_o;
        stall_at_rdy = stall_o;
        break;
      end
      if (stall_o) nstall++;
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    start_i = 1'b0;
    annul_i = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    resetn   = 1'b0;
    start_i  = 1'b0;
    signed_i = 1'b0;
    annul_i  = 1'b0;
    a_i      = '0;
    b_i      = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b expected 0", stall_o); end
    n_cmp++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b expected 0", ready_o); end
    n_cmp++; if (quot_o !== '0) begin n_err++; $display("FAIL reset_quot: got %h expected 0", quot_o); end
    n_cmp++; if (rem_o !== '0) begin n_err++; $display("FAIL reset_rem: got %h expected 0", rem_o); end
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  logic [W-1:0] d_a [7] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'd5, 32'h8000_0000, 32'd3, 32'hFFFF_FFFB};
  logic [W-1:0] d_b [7] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'd0, 32'hFFFF_FFFF, 32'd10, 32'd0};
  logic         d_s [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [W-1:0] d_q [7] = '{32'd14, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF};
  logic [W-1:0] d_r [7] = '{32'd2, 32'hFFFF_FFFF, 32'd1, 32'd5, 32'd0, 32'd3, 32'hFFFF_FFFB};

  task automatic test_directed();
    logic [W-1:0] q, r;
    int ns, rc, lat;
    logic sr;
    for (int i = 0; i < 7; i++) begin
      lat = model_lat(d_a[i], d_b[i], d_s[i]);
      run_div(d_a[i], d_b[i], d_s[i], q, r, ns, rc, sr);
      n_cmp++; if (q !== d_q[i]) begin n_err++; $display("FAIL dir%0d_quot: got %h expected %h", i, q, d_q[i]); end
      n_cmp++; if (r !== d_r[i]) begin n_err++; $display("FAIL dir%0d_rem: got %h expected %h", i, r, d_r[i]); end
      n_cmp++; if (ns != lat) begin n_err++; $display("FAIL dir%0d_stall_cycles: got %0d expected %0d", i, ns, lat); end
      n_cmp++; if (rc != lat) begin n_err++; $display("FAIL dir%0d_ready_cycle: got %0d expected %0d", i, rc, lat); end
      n_cmp++; if (sr !== 1'b0) begin n_err++; $display("FAIL dir%0d_stall_at_ready: got %b expected 0", i, sr); end
      idle(1);
    end
  endtask

  task automatic test_hold();
    idle(3);
    @(negedge clk);
    n_cmp++; if (quot_o !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL hold_quot: got %h expected ffffffff", quot_o); end
    n_cmp++; if (rem_o !== 32'hFFFF_FFFB) begin n_err++; $display("FAIL hold_rem: got %h expected fffffffb", rem_o); end
    n_cmp++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL hold_ready: got %b expected 0", ready_o); end
  endtask

  task automatic test_annul();
    logic [W-1:0] q, r;
    int ns, rc;
    logic sr;
    @(posedge clk); #1;
    start_i = 1'b1; annul_i = 1'b0; signed_i = 1'b0; a_i = 32'd100; b_i = 32'd7;
    repeat (10) begin @(posedge clk); #1; end
    annul_i = 1'b1;
    @(negedge clk);
    n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL annul_stall: got %b expected 0", stall_o); end
    n_cmp++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL annul_ready: got %b expected 0", ready_o); end
    run_div(32'd9, 32'd3, 1'b0, q, r, ns, rc, sr);
    n_cmp++; if (q !== 32'd3) begin n_err++; $display("FAIL annul_next_quot: got %h expected 3", q); end
    n_cmp++; if (r !== 32'd0) begin n_err++; $display("FAIL annul_next_rem: got %h expected 0", r); end
    n_cmp++; if (rc != W + 1) begin n_err++; $display("FAIL annul_next_ready_cycle: got %0d expected %0d", rc, W + 1); end
    n_cmp++; if (ns != W + 1) begin n_err++; $display("FAIL annul_next_stall_cycles: got %0d expected %0d", ns, W + 1); end
    idle(1);
  endtask

  task automatic test_start_drop();
    int rdy_seen;
    @(posedge clk); #1;
    start_i = 1'b1; annul_i = 1'b0; signed_i = 1'b0; a_i = 32'd1000; b_i = 32'd9;
    repeat (5) begin @(posedge clk); #1; end
    start_i = 1'b0;
    rdy_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o) rdy_seen++;
    end
    n_cmp++; if (rdy_seen != 0) begin n_err++; $display("FAIL start_drop_ready: got %0d ready cycles expected 0", rdy_seen); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b, q, r, eq, er;
    logic s, sr;
    int ns, rc, lat;
    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 28);
      s = 1'(i & 1);
      model(a, b, s, eq, er);
      lat = model_lat(a, b, s);
      run_div(a, b, s, q, r, ns, rc, sr);
      n_cmp++; if (q !== eq) begin n_err++; $display("FAIL b2b%0d_quot: got %h expected %h", i, q, eq); end
      n_cmp++; if (r !== er) begin n_err++; $display("FAIL b2b%0d_rem: got %h expected %h", i, r, er); end
      n_cmp++; if (rc != lat) begin n_err++; $display("FAIL b2b%0d_ready_cycle: got %0d expected %0d", i, rc, lat); end
    end
    idle(1);
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, q, r, eq, er;
    logic s, sr;
    int ns, rc, lat;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case ($urandom_range(0, 4))
        0:       b = W'($urandom_range(0, 20));
        1:       b = $urandom;
        2:       b = W'(-$signed(W'($urandom_range(1, 20))));
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(16, 31);
      s = 1'($urandom_range(0, 1));
      model(a, b, s, eq, er);
      lat = model_lat(a, b, s);
      run_div(a, b, s, q, r, ns, rc, sr);
      n_cmp++; if (q !== eq) begin n_err++; $display("FAIL rnd%0d_quot: a=%h b=%h s=%b got %h expected %h", i, a, b, s, q, eq); end
      n_cmp++; if (r !== er) begin n_err++; $display("FAIL rnd%0d_rem: a=%h b=%h s=%b got %h expected %h", i, a, b, s, r, er); end
      n_cmp++; if (ns != lat) begin n_err++; $display("FAIL rnd%0d_stall_cycles: got %0d expected %0d", i, ns, lat); end
      n_cmp++; if (rc != lat) begin n_err++; $display("FAIL rnd%0d_ready_cycle: got %0d expected %0d", i, rc, lat); end
      if ($urandom_range(0, 1) == 0) idle(1);
    end
    idle(1);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_annul();
    test_start_drop();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
